// File: rtl/gap_pulse_sort_pkg.sv
// Shared class codes, FSM encoding and default thresholds for the gap pulse classifier.
// Pure declarations: no latency, no flow control.
package gap_pulse_sort_pkg;

    typedef enum logic [1:0] {
        CLS_OPEN   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_ARC    = 2'd2,
        CLS_SHORT  = 2'd3
    } pulse_cls_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_BD = 2'd1,
        ST_BURN    = 2'd2,
        ST_REPORT  = 2'd3
    } gps_state_t;

    localparam logic [11:0] BD_CUR_DEF        = 12'd300;
    localparam logic [11:0] SHORT_VOL_DEF     = 12'd150;
    localparam logic [15:0] ARC_DELAY_DEF     = 16'd10;
    localparam logic [7:0]  SHORT_ALARM_N_DEF = 8'd8;

    // A burn is SHORT when more than half of its samples saw low gap voltage.
    function automatic logic is_short(input logic [15:0] short_cnt, input logic [15:0] burn_cnt);
        logic [16:0] twice;
        twice = {short_cnt, 1'b0};
        return twice > {1'b0, burn_cnt};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr restarts it at 0, or at 1 when inc is also high.
// One-cycle update latency; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = {W{1'b1}};

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? ONE : '0;
        end else if (inc && (q != MAX)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/gap_pulse_sort.sv
// Classifies each discharge window as OPEN/NORMAL/ARC/SHORT; class_valid 2 edges after pulse_win falls.
// No backpressure (strobes only); per-class statistics built when GAP_PULSE_SORT_STAT_EN is defined.
module gap_pulse_sort
    import gap_pulse_sort_pkg::*;
#(
    parameter logic [11:0] BD_CUR        = BD_CUR_DEF,
    parameter logic [11:0] SHORT_VOL     = SHORT_VOL_DEF,
    parameter logic [15:0] ARC_DELAY     = ARC_DELAY_DEF,
    parameter logic [7:0]  SHORT_ALARM_N = SHORT_ALARM_N_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pulse_win,
    input  logic [11:0] ad_ch1,
    input  logic [11:0] ad_ch2,
    input  logic        stat_clr,
    output logic [1:0]  pulse_class,
    output logic        class_valid,
    output logic        pro1_short_flag,
    output logic [15:0] bd_delay,
    output logic        short_alarm,
    output logic [15:0] cnt_open,
    output logic [15:0] cnt_normal,
    output logic [15:0] cnt_arc,
    output logic [15:0] cnt_short
);

    gps_state_t  state_q, state_d;
    pulse_cls_t  cls_q, cls_d;
    logic [15:0] dly_cnt, burn_cnt, short_cnt, delay_q;
    logic [7:0]  run_cnt;
    logic        dly_clr, dly_inc, burn_clr, burn_inc, sht_clr, sht_inc;
    logic        ld_delay, ld_cls, bd_hit, v_low, report, run_inc, run_clr;

    assign bd_hit = (ad_ch1 >= BD_CUR);
    assign v_low  = (ad_ch2 < SHORT_VOL);
    assign report = (state_q == ST_REPORT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = CLS_OPEN;
        dly_clr  = 1'b0;
        dly_inc  = 1'b0;
        burn_clr = 1'b0;
        burn_inc = 1'b0;
        sht_clr  = 1'b0;
        sht_inc  = 1'b0;
        ld_delay = 1'b0;
        ld_cls   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pulse_win) begin
                    state_d = ST_WAIT_BD;
                    dly_clr = 1'b1;
                    dly_inc = 1'b1;
                end
            end
            ST_WAIT_BD: begin
                // Window loss wins over a breakdown seen in the same cycle.
                if (!pulse_win) begin
                    state_d = ST_REPORT;
                    ld_cls  = 1'b1;
                    cls_d   = CLS_OPEN;
                end else if (bd_hit) begin
                    state_d  = ST_BURN;
                    ld_delay = 1'b1;
                    burn_clr = 1'b1;
                    burn_inc = 1'b1;
                    sht_clr  = 1'b1;
                    sht_inc  = v_low;
                end else begin
                    dly_inc = 1'b1;
                end
            end
            ST_BURN: begin
                if (pulse_win) begin
                    burn_inc = 1'b1;
                    sht_inc  = v_low;
                end else begin
                    state_d = ST_REPORT;
                    ld_cls  = 1'b1;
                    if (is_short(short_cnt, burn_cnt)) begin
                        cls_d = CLS_SHORT;
                    end else if (delay_q < ARC_DELAY) begin
                        cls_d = CLS_ARC;
                    end else begin
                        cls_d = CLS_NORMAL;
                    end
                end
            end
            ST_REPORT: begin
                if (pulse_win) begin
                    state_d = ST_WAIT_BD;
                    dly_clr = 1'b1;
                    dly_inc = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sat_counter #(.W(16)) u_dly   (.clk(clk), .rst(rst), .clr(dly_clr),  .inc(dly_inc),  .q(dly_cnt));
    sat_counter #(.W(16)) u_burn  (.clk(clk), .rst(rst), .clr(burn_clr), .inc(burn_inc), .q(burn_cnt));
    sat_counter #(.W(16)) u_short (.clk(clk), .rst(rst), .clr(sht_clr),  .inc(sht_inc),  .q(short_cnt));

    always_ff @(posedge clk) begin
        if (rst) begin
            delay_q <= '0;
            cls_q   <= CLS_OPEN;
        end else begin
            if (ld_delay) begin
                delay_q <= dly_cnt;
            end else if (ld_cls && (cls_d == CLS_OPEN)) begin
                delay_q <= '0;
            end
            if (ld_cls) begin
                cls_q <= cls_d;
            end
        end
    end

    assign run_inc = report && (cls_q == CLS_SHORT);
    assign run_clr = report && (cls_q != CLS_SHORT);

    sat_counter #(.W(8)) u_run (.clk(clk), .rst(rst), .clr(run_clr), .inc(run_inc), .q(run_cnt));

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_class     <= CLS_OPEN;
            class_valid     <= 1'b0;
            pro1_short_flag <= 1'b0;
            bd_delay        <= '0;
            short_alarm     <= 1'b0;
        end else begin
            class_valid     <= report;
            pro1_short_flag <= report && (cls_q == CLS_SHORT);
            short_alarm     <= (run_cnt >= SHORT_ALARM_N);
            if (report) begin
                pulse_class <= cls_q;
                bd_delay    <= delay_q;
            end
        end
    end

`ifdef GAP_PULSE_SORT_STAT_EN
    // Counters sample the registered strobe; stat_clr masks a coincident increment.
    logic inc_open, inc_normal, inc_arc, inc_short;

    assign inc_open   = class_valid && !stat_clr && (pulse_class == CLS_OPEN);
    assign inc_normal = class_valid && !stat_clr && (pulse_class == CLS_NORMAL);
    assign inc_arc    = class_valid && !stat_clr && (pulse_class == CLS_ARC);
    assign inc_short  = class_valid && !stat_clr && (pulse_class == CLS_SHORT);

    sat_counter #(.W(16)) u_cnt_open   (.clk(clk), .rst(rst), .clr(stat_clr), .inc(inc_open),   .q(cnt_open));
    sat_counter #(.W(16)) u_cnt_normal (.clk(clk), .rst(rst), .clr(stat_clr), .inc(inc_normal), .q(cnt_normal));
    sat_counter #(.W(16)) u_cnt_arc    (.clk(clk), .rst(rst), .clr(stat_clr), .inc(inc_arc),    .q(cnt_arc));
    sat_counter #(.W(16)) u_cnt_short  (.clk(clk), .rst(rst), .clr(stat_clr), .inc(inc_short),  .q(cnt_short));
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign cnt_open        = '0;
    assign cnt_normal      = '0;
    assign cnt_arc         = '0;
    assign cnt_short       = '0;
`endif

endmodule
